// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared FSM encodings and limits for the interrupt source controller
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_t;

  localparam int MAX_SRC = 8;

endpackage

// File: rtl/int_debounce.sv
// rtl/int_debounce.sv - per-source synchroniser, optional debouncer (INT_DEBOUNCE_EN) and rising-edge detector
module int_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("int_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic r_s1;
  logic r_s2;
  logic r_d;
  logic r_d_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_d_prev <= 1'b0;
    end else begin
      r_s1     <= raw;
      r_s2     <= r_s1;
      r_d_prev <= r_d;
    end
  end

`ifdef INT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CW-1:0] r_cnt;

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_d   <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 != r_d) begin
      if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_d   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_d <= 1'b0;
    end else begin
      r_d <= r_s2;
    end
  end
`endif

  assign rise = r_d & ~r_d_prev;

endmodule

// File: rtl/int_source_ctrl.sv
// rtl/int_source_ctrl.sv - pending bits, fixed-priority select and req/ack/eret FSM; INT_DEBOUNCE_EN enables debouncing
module int_source_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDW             = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] sw_int,
  input  logic [N_SRC-1:0] int_mask,
  input  logic             int_ack,
  input  logic             int_eret,
  output logic             int_req,
  output logic [IDW-1:0]   int_id,
  output logic [N_SRC-1:0] int_pending,
  output logic             in_service
);

  if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_cfg
    $error("int_source_ctrl: N_SRC out of range");
  end

  int_state_t       r_state;
  int_state_t       w_next;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_id_next;
  logic [IDW-1:0]   w_win;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_cand;
  logic [N_SRC-1:0] w_clr;
  logic             w_any;
  logic             w_ack_take;
  logic             r_int_req;
  logic             r_in_service;
  logic             w_req_next;
  logic             w_svc_next;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_int[g]),
      .rise (w_rise[g])
    );
  end

  assign w_ack_take = (r_state == ST_REQ) && int_ack;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    w_cand = r_pending & int_mask;
    w_any  = |w_cand;
    w_win  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = IDW'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = w_ack_take && (r_id == IDW'(i));
    end
  end

  // Set beats clear when a new edge lands on the bit being acknowledged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_id         <= '0;
      r_int_req    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_id         <= w_id_next;
      r_int_req    <= w_req_next;
      r_in_service <= w_svc_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_id_next = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next    = ST_REQ;
          w_id_next = w_win;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          w_next = ST_SERVICE;
        end else if (!int_mask[r_id]) begin
          w_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (int_eret) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_next = (w_next == ST_REQ);
    w_svc_next = (w_next == ST_SERVICE);
  end

  assign int_req     = r_int_req;
  assign int_id      = r_id;
  assign int_pending = r_pending;
  assign in_service  = r_in_service;

endmodule
